// File: rtl/fm_ctrl_pkg.sv
// Shared types and widths for the FM sweep controller.
package fm_ctrl_pkg;
  localparam int WORD_W      = 32;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SWEEP,
    ST_FINISH
  } state_t;
endpackage

// File: rtl/fm_step_sat.sv
// Combinational next-word generator: cur +/- step, clamped to stop, never wrapping.
module fm_step_sat
  import fm_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] cur,
  input  logic [WORD_W-1:0] step,
  input  logic [WORD_W-1:0] stop,
  input  logic              dir,
  output logic [WORD_W-1:0] next
);

  // dir=1 sweeps downward; the extra bit catches carry/borrow out of 32 bits
  function automatic logic [WORD_W-1:0] sat_step(input logic [WORD_W-1:0] c,
                                                 input logic [WORD_W-1:0] s,
                                                 input logic [WORD_W-1:0] p,
                                                 input logic              d);
    logic [WORD_W:0] ext;
    logic [WORD_W-1:0] res;
    if (!d) begin
      ext = {1'b0, c} + {1'b0, s};
      res = (ext[WORD_W] || (ext[WORD_W-1:0] > p)) ? p : ext[WORD_W-1:0];
    end else begin
      ext = {1'b0, c} - {1'b0, s};
      res = (ext[WORD_W] || (ext[WORD_W-1:0] < p)) ? p : ext[WORD_W-1:0];
    end
    return res;
  endfunction

  assign next = sat_step(cur, step, stop, dir);

endmodule

// File: rtl/fm_sweep_ctrl.sv
// Frequency sweep sequencer driving the FM modulator center word and deviation.
module fm_sweep_ctrl
  import fm_ctrl_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WORD_W-1:0]  start_word,
  input  logic [WORD_W-1:0]  stop_word,
  input  logic [WORD_W-1:0]  step_word,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mode,
  input  logic [4:0]         dev_in,
  input  logic               go,
  input  logic               abort,
  output logic [WORD_W-1:0]  ctr_ctrl,
  output logic [4:0]         deviation,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [WORD_W-1:0]  start_q;
  logic [WORD_W-1:0]  stop_q;
  logic [WORD_W-1:0]  step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               mode_q;
  logic [4:0]         dev_q;
  logic               dir_q;
  logic [DWELL_W-1:0] cnt;
  logic [WORD_W-1:0]  next_word;

  fm_step_sat u_step_sat (
    .cur  (ctr_ctrl),
    .step (step_q),
    .stop (stop_q),
    .dir  (dir_q),
    .next (next_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ctr_ctrl  <= '0;
      deviation <= '0;
      cnt       <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= 1'b0;
      dev_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            start_q   <= start_word;
            stop_q    <= stop_word;
            step_q    <= (step_word == '0) ? WORD_W'(1) : step_word;
            dwell_q   <= dwell;
            mode_q    <= mode;
            dev_q     <= dev_in;
            dir_q     <= (start_word > stop_word);
            cfg_ready <= 1'b0;
            state     <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (abort) begin
            cfg_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (go) begin
            ctr_ctrl  <= start_q;
            deviation <= dev_q;
            cnt       <= dwell_q;
            busy      <= 1'b1;
            state     <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (ctr_ctrl == stop_q) begin
            if (mode_q) begin
              // continuous mode wraps straight back to start with no idle cycle
              ctr_ctrl <= start_q;
              cnt      <= dwell_q;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_FINISH;
            end
          end else begin
            ctr_ctrl <= next_word;
            cnt      <= dwell_q;
          end
        end
        ST_FINISH: begin
          done      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_sweep_ctrl.sv
// Directed, table-driven bench for fm_sweep_ctrl.
module tb_fm_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] start_word, stop_word, step_word;
  logic [15:0] dwell;
  logic        mode;
  logic [4:0]  dev_in;
  logic        go, abort;
  logic [31:0] ctr_ctrl;
  logic [4:0]  deviation;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fm_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .start_word (start_word),
    .stop_word  (stop_word),
    .step_word  (step_word),
    .dwell      (dwell),
    .mode       (mode),
    .dev_in     (dev_in),
    .go         (go),
    .abort      (abort),
    .ctr_ctrl   (ctr_ctrl),
    .deviation  (deviation),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [31:0]      start;
    logic [31:0]      stop;
    logic [31:0]      step;
    logic [15:0]      dwell;
    logic [4:0]       dev;
    int               n;
    logic [5:0][31:0] w;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic configure(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                           input logic [15:0] d, input logic m, input logic [4:0] dv);
    start_word = s; stop_word = p; step_word = st; dwell = d; mode = m; dev_in = dv;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_ready_armed", 32'(cfg_ready), 32'd0);
  endtask

  task automatic fire_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 0; go = 0; abort = 0;
    start_word = 0; stop_word = 0; step_word = 0; dwell = 0; mode = 0; dev_in = 0;

    vecs[0] = '{32'd100, 32'd130, 32'd10, 16'd2, 5'd3, 4,
                {32'd0, 32'd0, 32'd130, 32'd120, 32'd110, 32'd100}};
    vecs[1] = '{32'd100, 32'd125, 32'd10, 16'd0, 5'd1, 4,
                {32'd0, 32'd0, 32'd125, 32'd120, 32'd110, 32'd100}};
    vecs[2] = '{32'd130, 32'd100, 32'd10, 16'd0, 5'd31, 4,
                {32'd0, 32'd0, 32'd100, 32'd110, 32'd120, 32'd130}};
    vecs[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 5'd2, 2,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0}};
    vecs[4] = '{32'd5, 32'd8, 32'd0, 16'd0, 5'd4, 4,
                {32'd0, 32'd0, 32'd8, 32'd7, 32'd6, 32'd5}};
    vecs[5] = '{32'd50, 32'd50, 32'd7, 16'd3, 5'd9, 1,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd50}};
    vecs[6] = '{32'h10, 32'h0, 32'h20, 16'd0, 5'd5, 2,
                {32'd0, 32'd0, 32'd0, 32'd0, 32'h0, 32'h10}};

    tick(); tick();
    rst = 1'b0;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_ctr", ctr_ctrl, 32'd0);
    chk("rst_dev", 32'(deviation), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // go/abort in IDLE are ignored
    go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    chk("idle_go_busy", 32'(busy), 32'd0);
    chk("idle_go_ready", 32'(cfg_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      configure(vecs[v].start, vecs[v].stop, vecs[v].step, vecs[v].dwell, 1'b0, vecs[v].dev);
      fire_go();
      chk("sweep_dev", 32'(deviation), 32'(vecs[v].dev));
      for (int i = 0; i < vecs[v].n; i++) begin
        for (int c = 0; c <= int'(vecs[v].dwell); c++) begin
          chk($sformatf("v%0d_word%0d", v, i), ctr_ctrl, vecs[v].w[i]);
          chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
          chk($sformatf("v%0d_ready", v), 32'(cfg_ready), 32'd0);
          tick();
        end
      end
      chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
      chk($sformatf("v%0d_fin_busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_fin_ready", v), 32'(cfg_ready), 32'd0);
      chk($sformatf("v%0d_fin_ctr", v), ctr_ctrl, vecs[v].stop);
      tick();
      chk($sformatf("v%0d_done_clr", v), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle_ready", v), 32'(cfg_ready), 32'd1);
      chk($sformatf("v%0d_idle_ctr", v), ctr_ctrl, vecs[v].stop);
    end

    // continuous mode wraps with no gap, then abort mid-dwell
    configure(32'd0, 32'd20, 32'd10, 16'd1, 1'b1, 5'd6);
    fire_go();
    begin
      logic [31:0] cont_exp[9];
      cont_exp = '{32'd0, 32'd0, 32'd10, 32'd10, 32'd20, 32'd20, 32'd0, 32'd0, 32'd10};
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("cont_word%0d", i), ctr_ctrl, cont_exp[i]);
        chk("cont_busy", 32'(busy), 32'd1);
        chk("cont_done", 32'(done), 32'd0);
        if (i < 8) tick();
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ctr", ctr_ctrl, 32'd10);
    chk("abort_dev", 32'(deviation), 32'd6);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(cfg_ready), 32'd1);
    tick();
    chk("abort_done2", 32'(done), 32'd0);
    chk("abort_ctr2", ctr_ctrl, 32'd10);

    // go and abort together while armed: abort wins
    configure(32'd500, 32'd600, 32'd50, 16'd0, 1'b0, 5'd1);
    go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    chk("goabort_busy", 32'(busy), 32'd0);
    chk("goabort_ready", 32'(cfg_ready), 32'd1);
    chk("goabort_ctr", ctr_ctrl, 32'd10);
    tick();
    chk("goabort_busy2", 32'(busy), 32'd0);

    // cfg_valid during a sweep must not disturb it
    configure(32'd0, 32'd30, 32'd10, 16'd0, 1'b0, 5'd2);
    fire_go();
    cfg_valid = 1'b1; start_word = 32'd999; stop_word = 32'd5; step_word = 32'd1; dev_in = 5'd17;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cfgsw_word%0d", i), ctr_ctrl, 32'(10 * i));
      chk("cfgsw_dev", 32'(deviation), 32'd2);
      if (i == 3) cfg_valid = 1'b0;
      tick();
    end
    chk("cfgsw_done", 32'(done), 32'd1);
    tick();
    chk("cfgsw_idle", 32'(cfg_ready), 32'd1);

    // reset in the middle of a sweep
    configure(32'd100, 32'd200, 32'd10, 16'd1, 1'b0, 5'd7);
    fire_go();
    tick(); tick(); tick();
    chk("prerst_ctr", ctr_ctrl, 32'd110);
    rst = 1'b1; go = 1'b1; cfg_valid = 1'b1;
    tick();
    rst = 1'b0; go = 1'b0; cfg_valid = 1'b0;
    chk("midrst_ctr", ctr_ctrl, 32'd0);
    chk("midrst_dev", 32'(deviation), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
